ahb_master: RTL and testbench



---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_master_if.sv | 29 ++
 rtl/ahb_master.sv | 143 ++++++++++++++
 tb/tb_ahb_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } ahb_state_e;

endpackage

// File: rtl/ahb_master_if.sv
// AHB-Lite bus bundle between one master and the interconnect/slave.
interface ahb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: an address phase with HTRANS=NONSEQ and a data phase each
  // complete only on a rising edge where HREADY=1; HRESP qualifies the data
  // phase, and ERROR/RETRY/SPLIT may be signalled while HREADY is still low.
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: turns one-cycle local read/write pulses
// into NONSEQ/SINGLE word transfers and reports completion, error and read data.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [3:0]  PROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_master_if.master      bus,
  input  logic              request_write,
  input  logic              request_read,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              error,
  output logic              busy,
  output ahb_state_e        state_dbg
);

  ahb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Write has priority; a simultaneous read is simply dropped.
        if (request_write) begin
          haddr_d  = write_addr;
          hwrite_d = 1'b1;
          wdata_d  = write_data;
          state_d  = ST_ADDR;
        end else if (request_read) begin
          haddr_d  = read_addr;
          hwrite_d = 1'b0;
          state_d  = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d = ST_DATA;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      ST_DATA: begin
        // ERROR aborts on its first response cycle, even while HREADY is low.
        if (bus.HRESP == HRESP_ERROR) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.HREADY) begin
          if (bus.HRESP == HRESP_OKAY) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (!hwrite_q) begin
              rdata_d       = bus.HRDATA;
              rdata_valid_d = 1'b1;
            end
          end else begin
            // RETRY and SPLIT: address and direction are unchanged, so
            // re-entering ADDR re-issues the identical transfer.
            state_d = ST_ADDR;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.HADDR  = haddr_q;
  assign bus.HWDATA = hwdata_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HPROT  = PROT_VAL;
  assign bus.HTRANS = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign error       = error_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: writes, reads, wait states, responses,
// request conflicts and mid-transfer reset, with hand-computed expectations.
module tb_ahb_master;
  import ahb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              HCLK;
  logic              HRESET;
  logic              request_write;
  logic              request_read;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              error;
  logic              busy;
  ahb_state_e        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT_VAL(4'b0011)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .bus           (bus),
    .request_write (request_write),
    .request_read  (request_read),
    .write_data    (write_data),
    .read_addr     (read_addr),
    .write_addr    (write_addr),
    .rdata         (rdata),
    .rdata_valid   (rdata_valid),
    .done          (done),
    .error         (error),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // Clock/reset block
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one rising edge and settle, so checks sample away from the edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET        = 1'b1;
    request_write = 1'b0;
    request_read  = 1'b0;
    write_data    = '0;
    read_addr     = '0;
    write_addr    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    bus.HRDATA    = '0;

    // Reset
    tick();
    tick();
    chk("rst_htrans", 64'(bus.HTRANS), 64'h0);
    chk("rst_haddr",  64'(bus.HADDR),  64'h0);
    chk("rst_hwrite", 64'(bus.HWRITE), 64'h0);
    chk("rst_hwdata", 64'(bus.HWDATA), 64'h0);
    chk("rst_hsize",  64'(bus.HSIZE),  64'h2);
    chk("rst_hburst", 64'(bus.HBURST), 64'h0);
    chk("rst_hprot",  64'(bus.HPROT),  64'h3);
    chk("rst_busy",   64'(busy),       64'h0);
    chk("rst_rdata",  64'(rdata),      64'h0);
    chk("rst_done",   64'(done),       64'h0);
    chk("rst_state",  64'(state_dbg),  64'(ST_IDLE));
    HRESET = 1'b0;
    tick();

    // Zero-wait write
    request_write = 1'b1;
    write_addr    = 32'h4000_0000;
    write_data    = 32'hA5A5_A5A5;
    tick();
    request_write = 1'b0;
    chk("wr_a_htrans", 64'(bus.HTRANS), 64'h2);
    chk("wr_a_haddr",  64'(bus.HADDR),  64'h4000_0000);
    chk("wr_a_hwrite", 64'(bus.HWRITE), 64'h1);
    chk("wr_a_busy",   64'(busy),       64'h1);
    chk("wr_a_done",   64'(done),       64'h0);
    tick();
    chk("wr_d_htrans", 64'(bus.HTRANS), 64'h0);
    chk("wr_d_hwdata", 64'(bus.HWDATA), 64'hA5A5_A5A5);
    chk("wr_d_busy",   64'(busy),       64'h1);
    chk("wr_d_done",   64'(done),       64'h0);
    tick();
    chk("wr_done",     64'(done),        64'h1);
    chk("wr_rvalid",   64'(rdata_valid), 64'h0);
    chk("wr_busy_off", 64'(busy),        64'h0);
    tick();
    chk("wr_done_once", 64'(done), 64'h0);

    // Zero-wait read
    bus.HRDATA   = 32'hDEAD_BEEF;
    request_read = 1'b1;
    read_addr    = 32'h4000_0004;
    tick();
    request_read = 1'b0;
    chk("rd_a_htrans", 64'(bus.HTRANS), 64'h2);
    chk("rd_a_hwrite", 64'(bus.HWRITE), 64'h0);
    chk("rd_a_haddr",  64'(bus.HADDR),  64'h4000_0004);
    tick();
    chk("rd_d_htrans", 64'(bus.HTRANS), 64'h0);
    chk("rd_d_hwdata_hold", 64'(bus.HWDATA), 64'hA5A5_A5A5);
    tick();
    chk("rd_rdata",  64'(rdata),       64'hDEAD_BEEF);
    chk("rd_rvalid", 64'(rdata_valid), 64'h1);
    chk("rd_done",   64'(done),        64'h1);
    tick();
    chk("rd_rvalid_once", 64'(rdata_valid), 64'h0);
    chk("rd_rdata_hold",  64'(rdata),       64'hDEAD_BEEF);

    // Wait states: 3 in address phase, 2 in data phase
    request_write = 1'b1;
    write_addr    = 32'h4000_0010;
    write_data    = 32'h1234_5678;
    bus.HREADY    = 1'b0;
    tick();
    request_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_a_htrans", 64'(bus.HTRANS), 64'h2);
      chk("ws_a_haddr",  64'(bus.HADDR),  64'h4000_0010);
      chk("ws_a_hwdata", 64'(bus.HWDATA), 64'hA5A5_A5A5);
    end
    bus.HREADY = 1'b1;
    tick();
    chk("ws_d_hwdata", 64'(bus.HWDATA), 64'h1234_5678);
    bus.HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ws_d_htrans", 64'(bus.HTRANS), 64'h0);
      chk("ws_d_hwdata", 64'(bus.HWDATA), 64'h1234_5678);
      chk("ws_d_done",   64'(done),       64'h0);
      chk("ws_d_busy",   64'(busy),       64'h1);
    end
    bus.HREADY = 1'b1;
    tick();
    chk("ws_done", 64'(done), 64'h1);
    tick();
    chk("ws_done_once", 64'(done), 64'h0);

    // ERROR response on a read: no done, no rdata update
    bus.HRDATA   = 32'hCAFE_F00D;
    request_read = 1'b1;
    read_addr    = 32'h4000_0020;
    tick();
    request_read = 1'b0;
    tick();
    chk("er_state_data", 64'(state_dbg), 64'(ST_DATA));
    bus.HRESP  = HRESP_ERROR;
    bus.HREADY = 1'b0;
    tick();
    chk("er_error",  64'(error),       64'h1);
    chk("er_done",   64'(done),        64'h0);
    chk("er_rvalid", 64'(rdata_valid), 64'h0);
    chk("er_rdata",  64'(rdata),       64'hDEAD_BEEF);
    chk("er_state",  64'(state_dbg),   64'(ST_IDLE));
    chk("er_busy",   64'(busy),        64'h0);
    bus.HRESP  = HRESP_OKAY;
    bus.HREADY = 1'b1;
    tick();
    chk("er_error_once", 64'(error), 64'h0);

    // RETRY response re-issues the same write
    request_write = 1'b1;
    write_addr    = 32'h4000_0030;
    write_data    = 32'h0BAD_F00D;
    tick();
    request_write = 1'b0;
    tick();
    bus.HRESP = HRESP_RETRY;
    tick();
    chk("rt_htrans", 64'(bus.HTRANS), 64'h2);
    chk("rt_haddr",  64'(bus.HADDR),  64'h4000_0030);
    chk("rt_hwrite", 64'(bus.HWRITE), 64'h1);
    chk("rt_done",   64'(done),       64'h0);
    chk("rt_error",  64'(error),      64'h0);
    bus.HRESP = HRESP_OKAY;
    tick();
    chk("rt_hwdata", 64'(bus.HWDATA), 64'h0BAD_F00D);
    tick();
    chk("rt_done2", 64'(done), 64'h1);

    // Simultaneous requests (write wins), then a request while busy
    request_write = 1'b1;
    request_read  = 1'b1;
    write_addr    = 32'h4000_0050;
    write_data    = 32'h1111_1111;
    read_addr     = 32'h4000_0060;
    tick();
    request_write = 1'b0;
    request_read  = 1'b0;
    chk("cf_haddr",  64'(bus.HADDR),  64'h4000_0050);
    chk("cf_hwrite", 64'(bus.HWRITE), 64'h1);
    request_read = 1'b1;
    read_addr    = 32'h4000_0070;
    tick();
    request_read = 1'b0;
    chk("cf_busy_data", 64'(state_dbg), 64'(ST_DATA));
    tick();
    chk("cf_done",   64'(done),       64'h1);
    chk("cf_rvalid", 64'(rdata_valid), 64'h0);
    tick();
    chk("cf_ignored_state", 64'(state_dbg),  64'(ST_IDLE));
    chk("cf_ignored_htrans", 64'(bus.HTRANS), 64'h0);
    chk("cf_haddr_hold",    64'(bus.HADDR),  64'h4000_0050);

    // Reset while in the data phase
    request_read = 1'b1;
    read_addr    = 32'h4000_0080;
    tick();
    request_read = 1'b0;
    bus.HREADY   = 1'b1;
    tick();
    bus.HREADY = 1'b0;
    tick();
    chk("rs_in_data", 64'(state_dbg), 64'(ST_DATA));
    HRESET = 1'b1;
    tick();
    chk("rs_state",  64'(state_dbg),  64'(ST_IDLE));
    chk("rs_htrans", 64'(bus.HTRANS), 64'h0);
    chk("rs_haddr",  64'(bus.HADDR),  64'h0);
    chk("rs_hwdata", 64'(bus.HWDATA), 64'h0);
    chk("rs_rdata",  64'(rdata),      64'h0);
    chk("rs_busy",   64'(busy),       64'h0);
    chk("rs_done",   64'(done),       64'h0);
    HRESET     = 1'b0;
    bus.HREADY = 1'b1;
    tick();
    chk("rs_stay_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
